// File: rtl/multisim_pull_upsizer_if.sv
`default_nettype none
// ============================================================================
// Module   : multisim_pull_upsizer_if
// Brief    : Narrow input stream, flush request and wide output stream for the
//            multisim pull upsizer.
// Revision : 1.0 - initial release
// ============================================================================
interface multisim_pull_upsizer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int RATIO      = 4
);
  localparam int BEATS_W = $clog2(RATIO + 1);

  logic                        in_vld;
  logic                        in_rdy;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        flush;
  logic                        out_vld;
  logic                        out_rdy;
  logic [DATA_WIDTH*RATIO-1:0] out_data;
  logic [BEATS_W-1:0]          out_beats;

  // Producer of beats / consumer of wide words
  modport master (
    output in_vld, in_data, flush, out_rdy,
    input  in_rdy, out_vld, out_data, out_beats
  );

  // The upsizer itself
  modport slave (
    input  in_vld, in_data, flush, out_rdy,
    output in_rdy, out_vld, out_data, out_beats
  );
endinterface
`default_nettype wire

// File: rtl/multisim_pull_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : multisim_pull_upsizer
// Brief    : Packs RATIO consecutive DATA_WIDTH beats into one registered wide
//            word; a flush emits a partially filled word (upper lanes zero).
// Revision : 1.0 - initial release
// ============================================================================
module multisim_pull_upsizer #(
  parameter int DATA_WIDTH = 64,
  parameter int RATIO      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  multisim_pull_upsizer_if.slave  bus
);
  localparam int CNT_W   = $clog2(RATIO);
  localparam int BEATS_W = $clog2(RATIO + 1);
  localparam int WORD_W  = DATA_WIDTH * RATIO;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic               flush_pend_q, flush_pend_d;
  logic               out_vld_q, out_vld_d;
  logic [WORD_W-1:0]  out_data_q, out_data_d;
  logic [BEATS_W-1:0] out_beats_q, out_beats_d;

  logic               out_free;
  logic               in_rdy;
  logic               accept;
  logic               service;
  logic               is_last;
  logic               load;
  logic [WORD_W-1:0]  word;
  logic [BEATS_W-1:0] word_beats;

  // Handshake qualifiers: output slot availability, input ready, flush service
  always_comb begin
    out_free = !out_vld_q || bus.out_rdy;
    is_last  = (cnt_q == LAST_CNT);
    // A non-final beat always fits; the final beat needs the output slot, and
    // a pending flush that cannot drain blocks further input.
    in_rdy   = !rst && (!is_last || out_free) && !(flush_pend_q && !out_free);
    accept   = bus.in_vld && in_rdy;
    service  = (bus.flush || flush_pend_q) && out_free;
  end

  // Candidate word: lanes above cnt are always zero in the accumulator, so the
  // accepted beat simply drops into lane cnt.
  always_comb begin
    word = acc_q;
    if (accept) begin
      word[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
    end
    word_beats = BEATS_W'(cnt_q) + BEATS_W'(accept);
    load       = (accept && is_last) || (service && (accept || cnt_q != '0));
  end

  // Next-state: completion/flush load, partial accumulate, flush bookkeeping
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    flush_pend_d = flush_pend_q;
    out_vld_d    = out_vld_q && !bus.out_rdy;
    out_data_d   = out_data_q;
    out_beats_d  = out_beats_q;

    if (load) begin
      out_vld_d    = 1'b1;
      out_data_d   = word;
      out_beats_d  = word_beats;
      cnt_d        = '0;
      acc_d        = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (accept) begin
        acc_d = word;
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (service) begin
        // Flush of an empty accumulator: nothing to emit, just retire it
        flush_pend_d = 1'b0;
      end else if (bus.flush) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_beats_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_beats_q  <= out_beats_d;
    end
  end

  assign bus.in_rdy    = in_rdy;
  assign bus.out_vld   = out_vld_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_beats = out_beats_q;

endmodule
`default_nettype wire

// File: doc/multisim_pull_upsizer.md
Name: multisim_pull_upsizer

Overview:
- Downstream stage of the multisim client pull block: consumes its DATA_WIDTH valid/ready stream and packs RATIO consecutive beats into one wide word for the DUT-side interface.
- Includes a flush path so a partially filled word can be emitted at end of message or end of test.
- Holds one accumulator and one output register. The wide output is registered and stays stable under back-pressure.

Parameters:
- DATA_WIDTH, 64, width of one input beat; matches the pull client's data width.
- RATIO, 4, input beats per output word; legal range 2..16.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- in_vld  input  1  input beat valid (from pull client data_vld).
- in_rdy  output  1  input ready (to pull client data_rdy).
- in_data  input  DATA_WIDTH  input beat.
- flush  input  1  single-cycle request to emit the current partial word.
- out_vld  output  1  wide word valid.
- out_rdy  input  1  downstream ready.
- out_data  output  DATA_WIDTH*RATIO  wide word; beat k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_beats  output  $clog2(RATIO+1)  number of valid beats in out_data (1..RATIO).

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports clk and rst.
- Reset values: out_vld=0, out_data=0, out_beats=0, beat counter cnt=0, flush_pend=0, accumulator=0. While rst=1, in_rdy=0.
- Handshakes:
  - Input beat accepted when in_vld && in_rdy. Output word transferred when out_vld && out_rdy.
  - in_rdy (combinational): in_rdy = !rst && (cnt != RATIO-1 || !out_vld || out_rdy) && !(flush_pend && out_vld && !out_rdy).
  - A non-final beat always fits. The final beat, or any beat while a flush is pending, needs the output register free or being freed this cycle.
- Output register:
  - out_data and out_beats stay stable while out_vld && !out_rdy.
  - out_vld drops the cycle after transfer, unless a new word loads in the same cycle.
- Accept without completion (cnt < RATIO-1, no flush):
  - Store the beat in lane cnt; cnt <= cnt+1.
- Completion (accept with cnt == RATIO-1):
  - Load out_data = {in_data, acc lanes RATIO-2..0}; out_beats <= RATIO; out_vld <= 1.
  - cnt <= 0; clear the accumulator.
- Latency: the final beat accepted in cycle N gives out_vld=1 in cycle N+1.
- Flush:
  - A pulse sets flush_pend, unless it is serviced in the same cycle.
  - Service condition: the output register is free or being freed this cycle.
  - On service with an accepted input beat the same cycle: that beat is included, out_beats = cnt+1, and the full-word completion takes priority if cnt == RATIO-1.
  - On service with no input beat and cnt > 0: emit cnt beats.
  - Unused upper lanes are zero. cnt <= 0; flush_pend <= 0.
  - flush with cnt == 0 and no input beat is a no-op; flush_pend is cleared and no output is produced.
  - A second flush while pending has no extra effect.
- Simultaneous events:
  - An output transfer and a new load in the same cycle: the new word replaces the old with out_vld held at 1, with no bubble.
  - Back-to-back full words at full rate, with out_rdy=1, sustain one input beat per cycle.
- Reset mid-operation: any partial word and any pending output are discarded. No output is produced for them after rst deasserts.
- Widths: cnt is $clog2(RATIO) bits and wraps only through completion or flush, never by overflow.

Test Plan:
- DATA_WIDTH=8, RATIO=4, out_rdy=1, beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after the 4th accept: out_vld=1, out_data=0x44332211, out_beats=4, with in_rdy high throughout.
- Same config, 8 beats 0x01..0x08, out_rdy=0 until cycle 10:
  - 0x04030201 is held stable while out_rdy=0.
  - in_rdy drops when the 8th beat is presented.
  - After out_rdy rises: 0x04030201, then 0x08070605.
- Beats 0xAA,0xBB, then a flush pulse with in_vld=0 -> out_data=0x0000BBAA, out_beats=2, cnt returns to 0.
- Beat 0xCC accepted in the same cycle as flush, with cnt=1 holding 0xAA -> out_data=0x0000CCAA, out_beats=2.
- Flush with out_vld=1 and out_rdy=0 and cnt=2 -> flush_pend holds, in_rdy=0. When out_rdy rises, the partial word loads the next cycle with out_beats=2.
- Three beats accepted, rst pulsed for 1 cycle, then 4 beats 0x01..0x04 -> outputs stay at reset values during rst, and the only word produced is 0x04030201.
